// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU operation sequencer:
//     - sequencer FSM state encoding
//     - 16-bit instruction field positions and a decode helper
//     - function codes that the sequencer itself needs to recognise
//   No ports; imported by alu_op_sequencer and alu_seq_regfile.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    // Instruction word geometry.
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned FUNC_W    = 4;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned IMM_W     = 5;

    // Field bit positions: [15:12] func, [11:10] rd, [9:8] ra, [7] use_imm,
    // [6:5] rb, [4:0] imm5.
    localparam int unsigned FUNC_MSB    = 15;
    localparam int unsigned FUNC_LSB    = 12;
    localparam int unsigned RD_MSB      = 11;
    localparam int unsigned RD_LSB      = 10;
    localparam int unsigned RA_MSB      = 9;
    localparam int unsigned RA_LSB      = 8;
    localparam int unsigned USE_IMM_BIT = 7;
    localparam int unsigned RB_MSB      = 6;
    localparam int unsigned RB_LSB      = 5;
    localparam int unsigned IMM_MSB     = 4;
    localparam int unsigned IMM_LSB     = 0;

    // Function codes for which the sequencer computes the overflow flag.
    localparam logic [FUNC_W-1:0] FN_ADD = 4'b0010;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'b0011;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWb   = 2'd2
    } state_e;

    // Decoded instruction.
    typedef struct packed {
        logic [FUNC_W-1:0]    func;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] ra;
        logic                 use_imm;
        logic [REG_IDX_W-1:0] rb;
        logic [IMM_W-1:0]     imm5;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] instr);
        instr_t d;
        d.func    = instr[FUNC_MSB:FUNC_LSB];
        d.rd      = instr[RD_MSB:RD_LSB];
        d.ra      = instr[RA_MSB:RA_LSB];
        d.use_imm = instr[USE_IMM_BIT];
        d.rb      = instr[RB_MSB:RB_LSB];
        d.imm5    = instr[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// ---------------------------------------------------------------------------
// alu_seq_regfile
//   Small operand register file: NREG entries of DATA_W bits.
//   Two combinational read ports (operands A/B), one combinational debug
//   read port and one synchronous write port. Synchronous active-low reset
//   clears every entry and has priority over a write.
//
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset
//     we        in   write enable
//     waddr     in   write index
//     wdata     in   write data
//     raddr_a   in   read index, port A
//     rdata_a   out  read data, port A
//     raddr_b   in   read index, port B
//     rdata_b   out  read data, port B
//     dbg_sel   in   debug read index
//     dbg_data  out  debug read data
// ---------------------------------------------------------------------------
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Reads are combinational so a write at the WB->IDLE edge is visible to
    // an instruction accepted in the very next cycle.
    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Three-state (IDLE -> EXEC -> WB) sequencer that feeds an external
//   combinational ALU. An instruction is accepted in IDLE; its operands are
//   fetched from the internal register file (or the zero-extended 5-bit
//   immediate for B) and held stable through EXEC and WB. The ALU result is
//   captured at the EXEC->WB edge, presented with a one-cycle o_done pulse
//   during WB, and written back to reg[rd] at the WB->IDLE edge.
//   Add carry / subtract borrow is computed locally, independent of the ALU.
//
//   Ports:
//     i_clk          in   clock, rising edge
//     i_rst_n        in   synchronous active-low reset
//     i_instr_valid  in   instruction offered
//     i_instr        in   16-bit instruction word
//     o_instr_ready  out  instruction accepted this cycle (IDLE only)
//     o_alu_a        out  ALU operand A
//     o_alu_b        out  ALU operand B
//     o_alu_func     out  ALU function code (passed through unchanged)
//     i_alu_result   in   combinational ALU result
//     o_done         out  one-cycle completion pulse (WB)
//     o_result       out  captured result, valid with o_done
//     o_ovf          out  carry-out / borrow, valid with o_done
//     i_dbg_sel      in   debug register index
//     o_dbg_data     out  combinational read of register i_dbg_sel
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_instr_valid,
    input  logic [INSTR_W-1:0]   i_instr,
    output logic                 o_instr_ready,
    output logic [DATA_W-1:0]    o_alu_a,
    output logic [DATA_W-1:0]    o_alu_b,
    output logic [FUNC_W-1:0]    o_alu_func,
    input  logic [DATA_W-1:0]    i_alu_result,
    output logic                 o_done,
    output logic [DATA_W-1:0]    o_result,
    output logic                 o_ovf,
    input  logic [REG_IDX_W-1:0] i_dbg_sel,
    output logic [DATA_W-1:0]    o_dbg_data
);

    state_e state_q, state_d;

    instr_t dec;

    logic accept;
    logic capture;
    logic reg_we;

    logic [FUNC_W-1:0]    func_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    result_q;
    logic                 ovf_q;

    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   sum_ext;
    logic              ovf_calc;

    assign dec     = decode_instr(i_instr);
    assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, dec.imm5};

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .we       (reg_we),
        .waddr    (rd_q),
        .wdata    (result_q),
        .raddr_a  (dec.ra),
        .rdata_a  (rf_rdata_a),
        .raddr_b  (dec.rb),
        .rdata_b  (rf_rdata_b),
        .dbg_sel  (i_dbg_sel),
        .dbg_data (o_dbg_data)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_instr_valid) state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs / datapath strobes
    // -----------------------------------------------------------------------
    always_comb begin
        o_instr_ready = 1'b0;
        o_done        = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        reg_we        = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_instr_ready = 1'b1;
                accept        = i_instr_valid;
            end
            StExec: begin
                capture = 1'b1;
            end
            StWb: begin
                o_done = 1'b1;
                reg_we = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Overflow flag, computed from the latched operands rather than taken
    // from the ALU so it does not depend on the external ALU's behaviour.
    // -----------------------------------------------------------------------
    assign sum_ext = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        ovf_calc = 1'b0;
        case (func_q)
            FN_ADD:  ovf_calc = sum_ext[DATA_W];
            FN_SUB:  ovf_calc = (a_q < b_q);
            default: ovf_calc = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand, function and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            func_q   <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                func_q <= dec.func;
                rd_q   <= dec.rd;
                a_q    <= rf_rdata_a;
                b_q    <= dec.use_imm ? imm_ext : rf_rdata_b;
            end
            if (capture) begin
                result_q <= i_alu_result;
                ovf_q    <= ovf_calc;
            end
        end
    end

    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_func = func_q;
    assign o_result   = result_q;
    assign o_ovf      = ovf_q;

endmodule
